b_lut_ctrl: RTL and testbench

B_LUT_CTRL -- requirements
Module: b_lut_ctrl

---
 rtl/b_lut_ctrl.sv | 127 ++++++++++++
 tb/tb_b_lut_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/b_lut_ctrl.sv
// rtl/b_lut_ctrl.sv - nibble lookup-table controller: eight 4-bit lookups into a 16-entry LUT
//
// Ports:
//   g_clk        in   clock, rising edge
//   g_rst        in   asynchronous active-high reset
//   req_valid    in   request operands valid
//   req_ready    out  high only in IDLE
//   req_lut_lo   in   LUT entries 0-7  (entry k = bits [4k+3:4k])
//   req_lut_hi   in   LUT entries 8-15 (entry 8+k = bits [4k+3:4k])
//   req_idx      in   eight 4-bit indices
//   flush        in   synchronous abort, overrides everything else
//   rsp_valid    out  high only in DONE
//   rsp_ready    in   consumer accepts result (looked at only in DONE)
//   rsp_result   out  nibble i = LUT[req_idx nibble i]
//   busy         out  high in BUSY or DONE
//
// Build option: define B_LUT_CTRL_DUAL_EN to resolve two nibbles per BUSY
// cycle (latency 4 instead of 8). Results are identical in both builds.
module b_lut_ctrl (
  input  logic        g_clk,
  input  logic        g_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_lut_lo,
  input  logic [31:0] req_lut_hi,
  input  logic [31:0] req_idx,
  input  logic        flush,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

`ifdef B_LUT_CTRL_DUAL_EN
  localparam logic [2:0] CNT_STEP = 3'd2;
  localparam logic [2:0] CNT_LAST = 3'd6;
`else
  localparam logic [2:0] CNT_STEP = 3'd1;
  localparam logic [2:0] CNT_LAST = 3'd7;
`endif

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [63:0] lut_q, lut_d;
  logic [31:0] idx_q, idx_d;
  logic [31:0] result_q, result_d;

  // Entry e of the combined table lives at bits [4e+3:4e].
  function automatic logic [3:0] lookup(input logic [63:0] lut, input logic [3:0] sel);
    return lut[{sel, 2'b00} +: 4];
  endfunction

  always_ff @(posedge g_clk or posedge g_rst) begin
    if (g_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      lut_q    <= 64'd0;
      idx_q    <= 32'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lut_q    <= lut_d;
      idx_q    <= idx_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lut_d    = lut_q;
    idx_d    = idx_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          lut_d    = {req_lut_hi, req_lut_lo};
          idx_d    = req_idx;
          cnt_d    = 3'd0;
          result_d = 32'd0;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        result_d[{cnt_q, 2'b00} +: 4] = lookup(lut_q, idx_q[{cnt_q, 2'b00} +: 4]);
`ifdef B_LUT_CTRL_DUAL_EN
        // cnt_q is always even here, so cnt_q | 1 is the odd partner nibble.
        result_d[{cnt_q | 3'd1, 2'b00} +: 4] =
          lookup(lut_q, idx_q[{cnt_q | 3'd1, 2'b00} +: 4]);
`endif
        // Counter wraps to 0 naturally after the last step.
        cnt_d = cnt_q + CNT_STEP;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Flush wins over acceptance and completion; operand registers are left
    // untouched since they are reloaded on the next acceptance anyway.
    if (flush) begin
      state_d  = S_IDLE;
      cnt_d    = 3'd0;
      lut_d    = lut_q;
      idx_d    = idx_q;
      result_d = 32'd0;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign rsp_result = result_q;

endmodule

// File: tb/tb_b_lut_ctrl.sv
// tb/tb_b_lut_ctrl.sv - self-checking bench for b_lut_ctrl (honours B_LUT_CTRL_DUAL_EN)
module tb_b_lut_ctrl;

  logic        g_clk = 1'b0;
  logic        g_rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_lut_lo = 32'd0;
  logic [31:0] req_lut_hi = 32'd0;
  logic [31:0] req_idx = 32'd0;
  logic        flush = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        busy;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

`ifdef B_LUT_CTRL_DUAL_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 8;
`endif

  b_lut_ctrl dut (
    .g_clk      (g_clk),
    .g_rst      (g_rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_lut_lo (req_lut_lo),
    .req_lut_hi (req_lut_hi),
    .req_idx    (req_idx),
    .flush      (flush),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .busy       (busy)
  );

  always #5 g_clk = ~g_clk;

  function automatic logic [31:0] model(input logic [31:0] lo, input logic [31:0] hi,
                                        input logic [31:0] idx);
    logic [3:0]  e [16];
    logic [31:0] r;
    r = 32'd0;
    for (int k = 0; k < 8; k++) begin
      e[k]     = lo[4*k +: 4];
      e[8 + k] = hi[4*k +: 4];
    end
    for (int i = 0; i < 8; i++) r[4*i +: 4] = e[idx[4*i +: 4]];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp(output int edges);
    edges = 0;
    while (edges < 20) begin
      @(posedge g_clk);
      #1;
      edges++;
      if (rsp_valid) break;
    end
  endtask

  task automatic pop_and_check(input string tag, output logic [31:0] e);
    check({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    check(tag, rsp_result, e);
  endtask

  task automatic run_txn(input string tag, input logic [31:0] lo, input logic [31:0] hi,
                         input logic [31:0] idx, input int bp);
    int n;
    logic [31:0] e;
    @(negedge g_clk);
    check({tag, "_ready_idle"}, 32'(req_ready), 32'd1);
    req_lut_lo = lo;
    req_lut_hi = hi;
    req_idx    = idx;
    req_valid  = 1'b1;
    exp_q.push_back(model(lo, hi, idx));
    @(posedge g_clk);
    #1;
    req_valid  = 1'b0;
    req_lut_lo = $urandom;
    req_lut_hi = $urandom;
    req_idx    = $urandom;
    check({tag, "_busy_rdy_vld"}, {29'd0, busy, req_ready, rsp_valid}, 32'b100);
    wait_rsp(n);
    check({tag, "_latency"}, n, LAT);
    pop_and_check({tag, "_result"}, e);
    for (int i = 0; i < bp; i++) begin
      req_valid = 1'b1;
      @(posedge g_clk);
      #1;
      check({tag, "_bp_hold"}, {29'd0, rsp_valid, req_ready, busy}, 32'b101);
      check({tag, "_bp_result"}, rsp_result, e);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge g_clk);
    #1;
    rsp_ready = 1'b0;
    check({tag, "_idle_after_ack"}, {29'd0, rsp_valid, req_ready, busy}, 32'b010);
    check({tag, "_retain"}, rsp_result, e);
  endtask

  initial begin
    int n;
    logic [31:0] e;
    logic seen;

    // Asynchronous reset, observed before any clock edge.
    #1 g_rst = 1'b1;
    #2;
    check("rst_outputs", {28'd0, req_ready, busy, rsp_valid, 1'b0}, 32'b1000);
    check("rst_result", rsp_result, 32'd0);
    @(negedge g_clk);
    g_rst = 1'b0;

    run_txn("identity", 32'h76543210, 32'hFEDCBA98, 32'h89ABCDEF, 0);
    check("identity_value", exp_q.size() == 0 ? rsp_result : 32'd0, 32'h89ABCDEF);
    run_txn("inv_zero", 32'h89ABCDEF, 32'h01234567, 32'h00000000, 0);
    check("inv_zero_value", rsp_result, 32'hFFFFFFFF);
    run_txn("inv_ones", 32'h89ABCDEF, 32'h01234567, 32'hFFFFFFFF, 5);
    check("inv_ones_value", rsp_result, 32'h00000000);
    for (int t = 0; t < 3; t++)
      run_txn("random", $urandom, $urandom, $urandom, t);

    // Flush during the third BUSY cycle.
    @(negedge g_clk);
    req_lut_lo = 32'h76543210;
    req_lut_hi = 32'hFEDCBA98;
    req_idx    = 32'h12345678;
    req_valid  = 1'b1;
    @(posedge g_clk);
    #1 req_valid = 1'b0;
    repeat (2) @(posedge g_clk);
    #1 flush = 1'b1;
    @(posedge g_clk);
    #1 flush = 1'b0;
    check("flush_state", {29'd0, rsp_valid, req_ready, busy}, 32'b010);
    check("flush_result", rsp_result, 32'd0);
    seen = 1'b0;
    repeat (12) begin
      @(posedge g_clk);
      #1 seen = seen | rsp_valid;
    end
    check("flush_no_rsp", 32'(seen), 32'd0);
    run_txn("after_flush", 32'h89ABCDEF, 32'h01234567, 32'h0F0F1E2D, 0);

    // Reset pulse mid-BUSY, placed between clock edges.
    @(negedge g_clk);
    req_lut_lo = $urandom;
    req_lut_hi = $urandom;
    req_idx    = $urandom;
    req_valid  = 1'b1;
    @(posedge g_clk);
    #1 req_valid = 1'b0;
    repeat (2) @(posedge g_clk);
    #3 g_rst = 1'b1;
    #1;
    check("midrst_outputs", {29'd0, req_ready, busy, rsp_valid}, 32'b100);
    check("midrst_result", rsp_result, 32'd0);
    #2 g_rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge g_clk);
      #1 seen = seen | rsp_valid;
    end
    check("midrst_no_rsp", 32'(seen), 32'd0);
    run_txn("after_rst", 32'h76543210, 32'hFEDCBA98, 32'hA5A5C3C3, 1);

    // Back-to-back with req_valid held high across two operand sets.
    @(negedge g_clk);
    req_lut_lo = 32'h76543210;
    req_lut_hi = 32'hFEDCBA98;
    req_idx    = 32'h01234567;
    req_valid  = 1'b1;
    exp_q.push_back(model(32'h76543210, 32'hFEDCBA98, 32'h01234567));
    exp_q.push_back(model(32'h89ABCDEF, 32'h01234567, 32'h13579BDF));
    @(posedge g_clk);
    #1;
    req_lut_lo = 32'h89ABCDEF;
    req_lut_hi = 32'h01234567;
    req_idx    = 32'h13579BDF;
    wait_rsp(n);
    check("b2b_lat1", n, LAT);
    pop_and_check("b2b_result1", e);
    rsp_ready = 1'b1;
    @(posedge g_clk);
    #1 rsp_ready = 1'b0;
    check("b2b_idle_gap", {29'd0, rsp_valid, req_ready, busy}, 32'b010);
    @(posedge g_clk);
    #1 req_valid = 1'b0;
    check("b2b_accept2", {29'd0, rsp_valid, req_ready, busy}, 32'b001);
    wait_rsp(n);
    check("b2b_lat2", n, LAT);
    pop_and_check("b2b_result2", e);
    rsp_ready = 1'b1;
    @(posedge g_clk);
    #1 rsp_ready = 1'b0;
    check("b2b_final_idle", {29'd0, rsp_valid, req_ready, busy}, 32'b010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
